// File: rtl/ringbuf_access_arbiter.sv
// Write arbitration and occupancy/flush control for one circular buffer shared by NUM_REQ writers and one reader.
// Define RINGBUF_ARB_STRICT_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module ringbuf_access_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 10,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          rd_req,
   output logic                          rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   input  logic                          flush,
   output logic                          flush_done,
   input  logic                          err_clr,
   output logic                          err_underflow,
   output logic                          buf_we,
   output logic [DATA_WIDTH-1:0]         buf_wdata,
   output logic                          buf_re,
   input  logic [DATA_WIDTH-1:0]         buf_rdata,
   output logic [CNT_W-1:0]              count,
   output logic                          full,
   output logic                          empty
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       count_reg, count_next;
   logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
   logic                   rd_valid_reg, flush_done_reg, flush_done_next;
   logic                   err_reg, err_next;
   logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
   logic [IDX_W-1:0]       winner_idx;
   logic                   winner_found;
   logic                   in_run, has_space, not_empty;
   logic                   wr_accept, rd_issue;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign has_space = (count_reg < CNT_W'(DEPTH));
   assign not_empty = (count_reg != '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= RUN;
      else        state_reg <= state_next;
   end

   // Next-state logic; a flush request while already flushing has no effect
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (flush) state_next = FLUSH;
         FLUSH:   if (!not_empty) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // State decode
   always_comb begin
      in_run          = 1'b0;
      flush_done_next = 1'b0;
      case (state_reg)
         RUN:     in_run = 1'b1;
         FLUSH:   flush_done_next = ~not_empty;
         default: in_run = 1'b0;
      endcase
   end

   // Later loop iterations override earlier ones, so the highest-priority candidate is visited last
   always_comb begin
      winner_found = 1'b0;
      winner_idx   = '0;
`ifdef RINGBUF_ARB_STRICT_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[IDX_W'(i)]) begin
            winner_found = 1'b1;
            winner_idx   = IDX_W'(i);
         end
      end
`else
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_valid[IDX_W'((int'(last_grant_reg) + k) % NUM_REQ)]) begin
            winner_found = 1'b1;
            winner_idx   = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
         end
      end
`endif
   end

   // Both enables use the registered count, so a same-cycle read never frees space for a write
   assign wr_accept = rst_n & in_run & winner_found & has_space;
   assign rd_issue  = rst_n & (in_run ? (rd_req & not_empty) : not_empty);

   assign req_ready = wr_accept ? (NUM_REQ'(1) << winner_idx) : '0;
   assign buf_we    = wr_accept;
   assign buf_wdata = wr_accept ? req_word[winner_idx] : '0;
   assign buf_re    = rd_issue;

   always_comb begin
      count_next = count_reg;
      if (wr_accept && !rd_issue)      count_next = count_reg + 1'b1;
      else if (!wr_accept && rd_issue) count_next = count_reg - 1'b1;
   end

`ifdef RINGBUF_ARB_STRICT_PRIO_EN
   assign last_grant_next = last_grant_reg;
`else
   assign last_grant_next = wr_accept ? winner_idx : last_grant_reg;
`endif

   always_comb begin
      err_next = err_reg;
      if (err_clr)                            err_next = 1'b0;
      else if (in_run && rd_req && !not_empty) err_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg      <= '0;
         last_grant_reg <= IDX_W'(NUM_REQ - 1);
         rd_valid_reg   <= 1'b0;
         flush_done_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         count_reg      <= count_next;
         last_grant_reg <= last_grant_next;
         rd_valid_reg   <= rd_issue & in_run;
         flush_done_reg <= flush_done_next;
         err_reg        <= err_next;
      end
   end

   assign rd_valid      = rd_valid_reg;
   assign rd_data       = buf_rdata;
   assign flush_done    = flush_done_reg;
   assign err_underflow = err_reg;
   assign count         = count_reg;
   assign full          = (count_reg == CNT_W'(DEPTH));
   assign empty         = (count_reg == '0);

endmodule

// File: tb/tb_ringbuf_access_arbiter.sv
// Randomised and directed bench for ringbuf_access_arbiter against a queue-based reference model and a simple buffer.
// Honours RINGBUF_ARB_STRICT_PRIO_EN so the same bench checks either arbitration build.
module tb_ringbuf_access_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 16;
   localparam int DEPTH   = 10;
   localparam int CNT_W   = 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [NUM_REQ*DW-1:0]  req_data = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   rd_req = 1'b0;
   logic                   rd_valid;
   logic [DW-1:0]          rd_data;
   logic                   flush = 1'b0;
   logic                   flush_done;
   logic                   err_clr = 1'b0;
   logic                   err_underflow;
   logic                   buf_we;
   logic [DW-1:0]          buf_wdata;
   logic                   buf_re;
   logic [DW-1:0]          buf_rdata;
   logic [CNT_W-1:0]       count;
   logic                   full;
   logic                   empty;

   ringbuf_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .flush(flush), .flush_done(flush_done),
      .err_clr(err_clr), .err_underflow(err_underflow), .buf_we(buf_we), .buf_wdata(buf_wdata),
      .buf_re(buf_re), .buf_rdata(buf_rdata), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // External circular buffer: registered read, pointers share rst_n
   logic [DW-1:0] mem [DEPTH];
   int            wp, rp;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= 0; rp <= 0; buf_rdata <= '0;
      end else begin
         if (buf_we) begin mem[wp] <= buf_wdata; wp <= (wp + 1) % DEPTH; end
         if (buf_re) begin buf_rdata <= mem[rp]; rp <= (rp + 1) % DEPTH; end
      end
   end

   // Reference model state (describes the cycle after the next edge once check_now returns)
   logic [DW-1:0]      q [$];
   bit                 m_flush, m_rdv, m_fdone, m_err;
   int                 m_last;
   logic [DW-1:0]      m_rdexp;
   logic [NUM_REQ-1:0] m_grant;
   logic [DW-1:0]      rq_data [NUM_REQ];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] v);
`ifdef RINGBUF_ARB_STRICT_PRIO_EN
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= NUM_REQ; k++) if (v[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_flush = 0; m_rdv = 0; m_fdone = 0; m_err = 0;
      m_last  = NUM_REQ - 1;
      m_rdexp = '0;
      m_grant = '0;
   endtask

   task automatic pack_req();
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = rq_data[i];
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare every DUT output with the model for the current inputs, then advance the model
   task automatic check_now();
      int                 sz, win;
      bit                 acc, re;
      logic [NUM_REQ-1:0] rexp;
      logic [DW-1:0]      wexp, popped;
      #1;
      sz   = q.size();
      win  = m_flush ? -1 : pick(req_valid);
      acc  = (win >= 0) && (sz < DEPTH);
      re   = m_flush ? (sz != 0) : (rd_req && sz != 0);
      rexp = '0;
      wexp = '0;
      if (acc) begin
         rexp[win] = 1'b1;
         wexp = req_data[win*DW +: DW];
      end
      m_grant = rexp;
      chk("req_ready", req_ready, rexp);
      chk("buf_we", buf_we, acc);
      chk("buf_wdata", buf_wdata, wexp);
      chk("buf_re", buf_re, re);
      chk("count", count, sz);
      chk("full", full, sz == DEPTH);
      chk("empty", empty, sz == 0);
      chk("rd_valid", rd_valid, m_rdv);
      if (m_rdv) chk("rd_data", rd_data, m_rdexp);
      chk("err_underflow", err_underflow, m_err);
      chk("flush_done", flush_done, m_fdone);
      popped = '0;
      if (re) popped = q.pop_front();
      if (acc) begin
         q.push_back(wexp);
         m_last = win;
      end
      if (err_clr) m_err = 0;
      else if (!m_flush && rd_req && sz == 0) m_err = 1;
      m_rdv   = re && !m_flush;
      m_rdexp = popped;
      m_fdone = 0;
      if (m_flush) begin
         if (sz == 0) begin m_flush = 0; m_fdone = 1; end
      end else if (flush) begin
         m_flush = 1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; flush = 0; rd_req = 0; err_clr = 0;
      req_valid = '1;
      pack_req();
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_buf_we", buf_we, 0);
      chk("rst_buf_re", buf_re, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_err", err_underflow, 0);
      chk("rst_flush_done", flush_done, 0);
      model_reset();
      req_valid = '0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NUM_REQ-1:0] seq_exp;
      int next_word, re_cnt, fd_cnt, rdy_cnt, rdv_cnt;
      for (int i = 0; i < NUM_REQ; i++) rq_data[i] = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Fill with words 1..10 from held requests
`ifdef RINGBUF_ARB_STRICT_PRIO_EN
      req_valid = 4'b1010; rq_data[1] = 16'd1; rq_data[3] = 16'h00EE; next_word = 2;
      seq_exp = 4'b0010;
`else
      req_valid = 4'b1111; next_word = 5;
      for (int i = 0; i < NUM_REQ; i++) rq_data[i] = 16'(i + 1);
      seq_exp = 4'b0001;
`endif
      for (int c = 0; c < 11; c++) begin
         pack_req();
         check_now();
         chk("fill_grant", req_ready, (c < 10) ? seq_exp : 4'b0000);
`ifndef RINGBUF_ARB_STRICT_PRIO_EN
         seq_exp = {seq_exp[NUM_REQ-2:0], seq_exp[NUM_REQ-1]};
`endif
         for (int i = 0; i < NUM_REQ; i++) if (m_grant[i]) rq_data[i] = 16'(next_word++);
         if (c == 10) begin
            chk("fill_full", full, 1);
            chk("fill_count", count, 10);
         end
         tick();
      end

      // Drain in order
      req_valid = '0;
      for (int c = 0; c <= 10; c++) begin
         rd_req = (c < 10);
         check_now();
         chk("rd_seq_re", buf_re, c < 10);
         chk("rd_seq_valid", rd_valid, c > 0);
         if (c > 0) chk("rd_seq_data", rd_data, c);
         if (c == 10) chk("rd_seq_empty", empty, 1);
         tick();
      end

      // Underflow is sticky until cleared
      rd_req = 1;
      check_now(); chk("uf_re", buf_re, 0); chk("uf_err0", err_underflow, 0); tick();
      rd_req = 0;
      check_now(); chk("uf_err1", err_underflow, 1); tick();
      err_clr = 1;
      check_now(); chk("uf_sticky", err_underflow, 1); tick();
      err_clr = 0;
      check_now(); chk("uf_cleared", err_underflow, 0); tick();

      // Full with same-cycle read: write waits one cycle
      req_valid = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         rq_data[0] = 16'(16'h0100 + c);
         pack_req(); check_now(); tick();
      end
      rq_data[0] = 16'h0200; pack_req();
      rd_req = 1;
      check_now(); chk("fr_reject", req_ready, 0); chk("fr_re", buf_re, 1); tick();
      rd_req = 0;
      check_now(); chk("fr_cnt9", count, 9); chk("fr_accept", req_ready, 1); tick();
      req_valid = '0;
      check_now(); chk("fr_cnt10", count, 10); tick();

      // Flush from count 5
      rd_req = 1;
      for (int c = 0; c < 5; c++) begin check_now(); tick(); end
      rd_req = 0; flush = 1;
      check_now(); chk("fl_start_cnt", count, 5); tick();
      flush = 0; req_valid = '1; rd_req = 1; pack_req();
      re_cnt = 0; fd_cnt = 0; rdy_cnt = 0; rdv_cnt = 0;
      for (int c = 0; c < 7; c++) begin
         check_now();
         re_cnt += int'(buf_re);
         fd_cnt += int'(flush_done);
         if (!flush_done) rdy_cnt += int'(req_ready != '0);
         rdv_cnt += int'(rd_valid);
         if (c == 6) begin
            chk("fl_done", flush_done, 1);
            chk("fl_count0", count, 0);
            chk("fl_no_err", err_underflow, 0);
         end
         tick();
      end
      chk("fl_re_cycles", re_cnt, 5);
      chk("fl_done_pulses", fd_cnt, 1);
      chk("fl_ready_cycles", rdy_cnt, 0);
      chk("fl_rdvalid_cycles", rdv_cnt, 0);
      req_valid = '0; rd_req = 0; err_clr = 1;
      check_now(); tick();
      err_clr = 0;

      // Randomised traffic with one mid-run reset
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (m_grant[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               req_valid[i] = 1'b1;
               rq_data[i]   = 16'($urandom);
            end
         end
         rd_req  = ($urandom_range(0, 99) < (((c / 300) % 2 == 1) ? 85 : 35));
         flush   = ($urandom_range(0, 59) == 0);
         err_clr = ($urandom_range(0, 19) == 0);
         pack_req();
         check_now();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ringbuf_access_arbiter.md
Name: ringbuf_access_arbiter

Overview:
- Shares one circular data buffer between NUM_REQ write requesters and one reader in the IFC CPLD test datapath.
- Round-robin arbitration across writers.
- Tracks occupancy and drives the buffer's write_enable/read_enable so it never overflows or underflows.
- Provides a flush sequence that drains the buffer, and a sticky underflow error.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- DATA_WIDTH, 16, data word width; must match the buffer.
- DEPTH, 10, buffer capacity in words; must equal the buffer's BUFFER_SIZE.
- CNT_W, 8, occupancy counter width; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept, combinational.
- rd_req  in  1  reader pops one word.
- rd_valid  out  1  rd_data valid, registered.
- rd_data  out  DATA_WIDTH  read word, wired from buf_rdata.
- flush  in  1  single-cycle pulse; drains the buffer.
- flush_done  out  1  single-cycle pulse when drain completes.
- err_clr  in  1  clears err_underflow.
- err_underflow  out  1  sticky flag: rd_req while empty.
- buf_we  out  1  to buffer write_enable.
- buf_wdata  out  DATA_WIDTH  to buffer data_in.
- buf_re  out  1  to buffer read_enable.
- buf_rdata  in  DATA_WIDTH  from buffer data_out; registered in the buffer, 1-cycle latency.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values:
  - state = RUN, count = 0, last_grant = NUM_REQ-1 (so the first grant goes to requester 0).
  - rd_valid = 0, flush_done = 0, err_underflow = 0.
  - req_ready, buf_we and buf_re are 0 while rst_n is low.
  - Reset mid-flush or mid-read returns to this state immediately. The buffer shares rst_n, so its pointers realign.
- FSM states:
  - RUN → FLUSH on flush=1.
  - FLUSH → RUN when count == 0; flush_done pulses high for one cycle in the first RUN cycle.
  - flush=1 while in FLUSH is ignored.
  - flush=1 in RUN with count == 0 enters FLUSH and returns next cycle with flush_done.
- Write arbitration (RUN only):
  - Search req_valid starting at index last_grant+1, wrapping modulo NUM_REQ; the first set bit wins.
  - The winner is accepted iff count < DEPTH. count here is the registered value; same-cycle reads are not credited.
  - On accept: req_ready[winner] = 1, buf_we = 1, buf_wdata = winner's slice, last_grant <= winner.
  - Otherwise req_ready = 0, buf_we = 0, and last_grant is held.
  - buf_wdata = 0 when buf_we = 0.
  - A requester holds req_valid and its data until it sees req_ready.
- Read (RUN only):
  - buf_re = rd_req & (count != 0).
  - rd_valid <= buf_re, so it is asserted exactly 1 cycle after buf_re; rd_data = buf_rdata.
  - Back-to-back rd_req yields back-to-back rd_valid.
  - rd_req while count == 0: no buf_re, and err_underflow <= 1.
  - err_clr has priority over a simultaneous set.
- FLUSH:
  - req_ready = 0 throughout.
  - buf_re = 1 every cycle while count != 0.
  - rd_valid stays 0 for flushed words; rd_req is ignored and no error is raised.
- Count update (per cycle):
  - +1 on write only, -1 on read only, unchanged on both or neither.
  - Saturation cannot occur by construction.
- Boundary cases:
  - full with a same-cycle read: the read is performed, the write is rejected that cycle and accepted the next.
  - empty with a same-cycle write: the read is not issued.
- Derived outputs: full and empty are combinational decodes of count.

Optional Feature:
- Macro: RINGBUF_ARB_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins every cycle; last_grant is unused (held at reset value).
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then req_valid=4'b1111 held, rd_req=0 → grants 0,1,2,3,0,1,2,3,0,1 on consecutive cycles; count reaches 10, full=1; req_ready=0 on cycle 11.
- Fill 10 words 0x0001..0x000A, then rd_req held 10 cycles → rd_valid high 1 cycle after each buf_re; rd_data 0x0001..0x000A in order; empty=1 after.
- count=10 with req_valid=4'b0001 and rd_req=1 in the same cycle → write rejected, count=9; next cycle write accepted, count=10.
- Empty buffer with rd_req=1 → buf_re=0, err_underflow=1 and sticky; err_clr=1 → 0 the next cycle.
- count=5, then flush pulse → 5 cycles of buf_re, rd_valid=0, req_ready=0; count=0; flush_done pulses once; state back to RUN.
- With the macro defined, req_valid=4'b1010 held → requester 1 is granted every cycle until full; requester 3 is never granted.
